// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared encodings for the data-memory arbiter (FSM states,
// access owner, memory size codes).
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StIssue  = 2'd1,
        StRdwait = 2'd2,
        StResp   = 2'd3
    } arb_state_e;

    typedef enum logic {
        OwnCpu = 1'b0,
        OwnDbg = 1'b1
    } owner_e;

    localparam logic [1:0] SzByte = 2'b00;
    localparam logic [1:0] SzHalf = 2'b01;
    localparam logic [1:0] SzWord = 2'b11;

    // Wide enough for any starvation limit up to 255.
    localparam int unsigned StarveCntW = 8;

endpackage

// File: rtl/dmem_arb_sel.sv
// dmem_arb_sel: fixed cpu-priority select with starvation protection for dbg.
// Grants are only issued while arb_en_i is high (arbiter idle).
module dmem_arb_sel
    import dmem_arb_pkg::*;
#(
    parameter int unsigned StarveLimit = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic arb_en_i,
    input  logic cpu_req_i,
    input  logic dbg_req_i,
    output logic grant_o,
    output logic grant_dbg_o
);

    localparam logic [StarveCntW-1:0] Limit = StarveCntW'(StarveLimit);

    logic [StarveCntW-1:0] starve_q, starve_d;
    logic                  starved;

    // Priority decision and saturating count of dbg's lost arbitrations.
    always_comb begin
        starved     = (starve_q == Limit);
        grant_o     = arb_en_i & (cpu_req_i | dbg_req_i);
        grant_dbg_o = arb_en_i & dbg_req_i & (~cpu_req_i | starved);
        starve_d    = starve_q;
        if (arb_en_i) begin
            if (!dbg_req_i || grant_dbg_o) begin
                starve_d = '0;
            end else if (cpu_req_i && !starved) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    // Starvation counter state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data_memory port between the cpu load/store path
// and the debug/boot-loader requester. Optional performance counters are
// built when DMEM_ARB_PERF_EN is defined.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned AW           = 32,
    parameter int unsigned DW           = 32,
    parameter int unsigned RD_LATENCY   = 1,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic          clock,
    input  logic          reset,
`ifdef DMEM_ARB_PERF_EN
    input  logic          perf_clr_in,
    output logic [31:0]   cpu_stall_cnt_out,
    output logic [15:0]   dbg_grant_cnt_out,
`endif
    input  logic          cpu_req_in,
    input  logic          cpu_we_in,
    input  logic [AW-1:0] cpu_addr_in,
    input  logic [DW-1:0] cpu_wdata_in,
    input  logic [1:0]    cpu_size_in,
    output logic          cpu_done_out,
    output logic [DW-1:0] cpu_rdata_out,
    output logic          cpu_stall_out,
    input  logic          dbg_req_in,
    input  logic          dbg_we_in,
    input  logic [AW-1:0] dbg_addr_in,
    input  logic [DW-1:0] dbg_wdata_in,
    input  logic [1:0]    dbg_size_in,
    output logic          dbg_done_out,
    output logic [DW-1:0] dbg_rdata_out,
    output logic [AW-1:0] mem_addr_out,
    output logic          mem_re_out,
    output logic          mem_we_out,
    output logic [DW-1:0] mem_wdata_out,
    output logic [1:0]    mem_size_out,
    input  logic [DW-1:0] mem_rdata_in
);

    localparam logic [1:0] RdLat = 2'(RD_LATENCY);

    arb_state_e    state_q;
    owner_e        owner_q;
    logic [1:0]    rd_cnt_q;
    logic          cpu_done_q, dbg_done_q;
    logic [DW-1:0] cpu_rdata_q, dbg_rdata_q;
    logic          mem_re_q, mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic [1:0]    mem_size_q;

    logic          cpu_req_eff, dbg_req_eff, arb_en;
    logic          grant, grant_dbg;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic [1:0]    sel_size;

    // A requester whose done is showing this cycle is finishing, not asking again.
    always_comb begin
        cpu_req_eff = cpu_req_in & ~cpu_done_q;
        dbg_req_eff = dbg_req_in & ~dbg_done_q;
        arb_en      = (state_q == StIdle);
    end

    dmem_arb_sel #(
        .StarveLimit (STARVE_LIMIT)
    ) u_sel (
        .clk_i       (clock),
        .rst_ni      (reset),
        .arb_en_i    (arb_en),
        .cpu_req_i   (cpu_req_eff),
        .dbg_req_i   (dbg_req_eff),
        .grant_o     (grant),
        .grant_dbg_o (grant_dbg)
    );

    // Request fields of the winning requester.
    always_comb begin
        if (grant_dbg) begin
            sel_we    = dbg_we_in;
            sel_addr  = dbg_addr_in;
            sel_wdata = dbg_wdata_in;
            sel_size  = dbg_size_in;
        end else begin
            sel_we    = cpu_we_in;
            sel_addr  = cpu_addr_in;
            sel_wdata = cpu_wdata_in;
            sel_size  = cpu_size_in;
        end
    end

    // Access FSM with registered memory-side strobes, done pulses and read data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            owner_q     <= OwnCpu;
            rd_cnt_q    <= 2'd0;
            cpu_done_q  <= 1'b0;
            dbg_done_q  <= 1'b0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_size_q  <= SzWord;
        end else begin
            cpu_done_q <= 1'b0;
            dbg_done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (grant) begin
                        owner_q     <= grant_dbg ? OwnDbg : OwnCpu;
                        mem_addr_q  <= sel_addr;
                        mem_wdata_q <= sel_wdata;
                        mem_size_q  <= sel_size;
                        mem_we_q    <= sel_we;
                        mem_re_q    <= ~sel_we;
                        state_q     <= StIssue;
                    end
                end
                StIssue: begin
                    if (mem_we_q) begin
                        mem_we_q <= 1'b0;
                        if (owner_q == OwnDbg) begin
                            dbg_done_q <= 1'b1;
                        end else begin
                            cpu_done_q <= 1'b1;
                        end
                        state_q <= StIdle;
                    end else begin
                        // The issue cycle already counts toward the read latency.
                        rd_cnt_q <= 2'd1;
                        state_q  <= StRdwait;
                    end
                end
                StRdwait: begin
                    if (rd_cnt_q == RdLat) begin
                        mem_re_q <= 1'b0;
                        if (owner_q == OwnDbg) begin
                            dbg_rdata_q <= mem_rdata_in;
                            dbg_done_q  <= 1'b1;
                        end else begin
                            cpu_rdata_q <= mem_rdata_in;
                            cpu_done_q  <= 1'b1;
                        end
                        state_q <= StResp;
                    end else begin
                        rd_cnt_q <= rd_cnt_q + 2'd1;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Output wiring.
    always_comb begin
        cpu_done_out  = cpu_done_q;
        dbg_done_out  = dbg_done_q;
        cpu_rdata_out = cpu_rdata_q;
        dbg_rdata_out = dbg_rdata_q;
        cpu_stall_out = cpu_req_in & ~cpu_done_q;
        mem_addr_out  = mem_addr_q;
        mem_re_out    = mem_re_q;
        mem_we_out    = mem_we_q;
        mem_wdata_out = mem_wdata_q;
        mem_size_out  = mem_size_q;
    end

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [15:0] dbg_grant_cnt_q;

    // Wrapping perf counters: cpu stall cycles and dbg grants.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cnt_q     <= '0;
            dbg_grant_cnt_q <= '0;
        end else if (perf_clr_in) begin
            stall_cnt_q     <= '0;
            dbg_grant_cnt_q <= '0;
        end else begin
            if (cpu_stall_out) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (grant_dbg) begin
                dbg_grant_cnt_q <= dbg_grant_cnt_q + 16'd1;
            end
        end
    end

    always_comb begin
        cpu_stall_cnt_out = stall_cnt_q;
        dbg_grant_cnt_out = dbg_grant_cnt_q;
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench with a transaction-timeline model of the
// arbiter, checked every cycle, plus hand-computed latency/data expectations.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int L     = 2;
    localparam int LIMIT = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req_in = 1'b0, cpu_we_in = 1'b0;
    logic [31:0] cpu_addr_in = '0, cpu_wdata_in = '0;
    logic [1:0]  cpu_size_in = SzWord;
    logic        dbg_req_in = 1'b0, dbg_we_in = 1'b0;
    logic [31:0] dbg_addr_in = '0, dbg_wdata_in = '0;
    logic [1:0]  dbg_size_in = SzWord;
    logic        cpu_done_out, cpu_stall_out, dbg_done_out;
    logic [31:0] cpu_rdata_out, dbg_rdata_out;
    logic [31:0] mem_addr_out, mem_wdata_out, mem_rdata_in;
    logic        mem_re_out, mem_we_out;
    logic [1:0]  mem_size_out;
`ifdef DMEM_ARB_PERF_EN
    logic        perf_clr_in = 1'b0;
    logic [31:0] cpu_stall_cnt_out;
    logic [15:0] dbg_grant_cnt_out;
`endif

    int n_vec = 0;
    int n_err = 0;

    dmem_arbiter #(
        .AW           (32),
        .DW           (32),
        .RD_LATENCY   (L),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clock             (clock),
        .reset             (reset),
`ifdef DMEM_ARB_PERF_EN
        .perf_clr_in       (perf_clr_in),
        .cpu_stall_cnt_out (cpu_stall_cnt_out),
        .dbg_grant_cnt_out (dbg_grant_cnt_out),
`endif
        .cpu_req_in        (cpu_req_in),
        .cpu_we_in         (cpu_we_in),
        .cpu_addr_in       (cpu_addr_in),
        .cpu_wdata_in      (cpu_wdata_in),
        .cpu_size_in       (cpu_size_in),
        .cpu_done_out      (cpu_done_out),
        .cpu_rdata_out     (cpu_rdata_out),
        .cpu_stall_out     (cpu_stall_out),
        .dbg_req_in        (dbg_req_in),
        .dbg_we_in         (dbg_we_in),
        .dbg_addr_in       (dbg_addr_in),
        .dbg_wdata_in      (dbg_wdata_in),
        .dbg_size_in       (dbg_size_in),
        .dbg_done_out      (dbg_done_out),
        .dbg_rdata_out     (dbg_rdata_out),
        .mem_addr_out      (mem_addr_out),
        .mem_re_out        (mem_re_out),
        .mem_we_out        (mem_we_out),
        .mem_wdata_out     (mem_wdata_out),
        .mem_size_out      (mem_size_out),
        .mem_rdata_in      (mem_rdata_in)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] init_word(input int i);
        return (i == 8) ? 32'h1234_5678 : (32'hA000_0000 + 32'(i));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Memory: 16 words, data valid exactly L cycles after re first rises.
    logic [31:0] env_mem [16];
    bit          env_wr [16];
    int          re_age = 0;

    always @(posedge clock) begin
        if (mem_we_out) begin
            env_mem[mem_addr_out[5:2]] <= mem_wdata_out;
            env_wr[mem_addr_out[5:2]]  <= 1'b1;
        end
        re_age <= mem_re_out ? re_age + 1 : 0;
    end

    always_comb begin
        if (re_age == L) begin
            mem_rdata_in = env_wr[mem_addr_out[5:2]] ? env_mem[mem_addr_out[5:2]]
                                                     : init_word(int'(mem_addr_out[5:2]));
        end else begin
            mem_rdata_in = 32'hBAD0_BAD0;
        end
    end

    // Timeline model: an access granted in cycle g makes mem_we visible at g+1
    // (store) or mem_re at g+1..g+L+1 (load); done at g+2 (store) or g+L+2.
    initial begin : model
        bit          act, own_dbg, m_we, dk, can_arb, ce, de, dw;
        bit          e_we, e_re, e_cd, e_dd;
        int          k, starve;
        logic [31:0] m_addr, m_wdata, m_crd, m_drd;
        logic [1:0]  m_size;
        logic [31:0] mm [16];
        for (int i = 0; i < 16; i++) mm[i] = init_word(i);
        act = 0; own_dbg = 0; m_we = 0; k = 0; starve = 0;
        m_addr = '0; m_wdata = '0; m_crd = '0; m_drd = '0; m_size = SzWord;
        forever begin
            @(negedge clock);
            if (!reset) begin
                act = 0; k = 0; starve = 0; m_we = 0;
                m_addr = '0; m_wdata = '0; m_crd = '0; m_drd = '0; m_size = SzWord;
            end else begin
                dk   = act && (k == (m_we ? 2 : L + 2));
                e_we = act && m_we && (k == 1);
                e_re = act && !m_we && (k >= 1) && (k <= L + 1);
                e_cd = dk && !own_dbg;
                e_dd = dk && own_dbg;
                if (dk && !m_we) begin
                    if (own_dbg) m_drd = mm[m_addr[5:2]];
                    else m_crd = mm[m_addr[5:2]];
                end
                chk("cyc_cpu_done", 32'(cpu_done_out), 32'(e_cd));
                chk("cyc_dbg_done", 32'(dbg_done_out), 32'(e_dd));
                chk("cyc_mem_we", 32'(mem_we_out), 32'(e_we));
                chk("cyc_mem_re", 32'(mem_re_out), 32'(e_re));
                chk("cyc_mem_addr", mem_addr_out, m_addr);
                chk("cyc_mem_wdata", mem_wdata_out, m_wdata);
                chk("cyc_mem_size", 32'(mem_size_out), 32'(m_size));
                chk("cyc_cpu_rdata", cpu_rdata_out, m_crd);
                chk("cyc_dbg_rdata", dbg_rdata_out, m_drd);
                chk("cyc_cpu_stall", 32'(cpu_stall_out), 32'(cpu_req_in && !e_cd));
                can_arb = !act || (dk && m_we);
                if (act && !dk) k++;
                if (dk) act = 0;
                if (can_arb) begin
                    ce = cpu_req_in && !e_cd;
                    de = dbg_req_in && !e_dd;
                    if (ce || de) begin
                        dw = de && (!ce || starve == LIMIT);
                        if (dw || !de) starve = 0;
                        else if (starve < LIMIT) starve++;
                        own_dbg = dw;
                        act     = 1;
                        k       = 1;
                        m_we    = dw ? dbg_we_in : cpu_we_in;
                        m_addr  = dw ? dbg_addr_in : cpu_addr_in;
                        m_wdata = dw ? dbg_wdata_in : cpu_wdata_in;
                        m_size  = dw ? dbg_size_in : cpu_size_in;
                        if (m_we) mm[m_addr[5:2]] = m_wdata;
                    end else begin
                        starve = 0;
                    end
                end
            end
        end
    end

    // Requester drivers: called just after a rising edge; lat counts cycles
    // from req assertion to the cycle done is seen.
    task automatic cpu_access(input bit we, input logic [31:0] a, input logic [31:0] wd,
                              input logic [1:0] sz, output int lat, output logic [31:0] rd);
        cpu_we_in = we; cpu_addr_in = a; cpu_wdata_in = wd; cpu_size_in = sz;
        cpu_req_in = 1'b1;
        lat = 0;
        @(negedge clock);
        while (!cpu_done_out && lat < 60) begin
            lat++;
            @(negedge clock);
        end
        if (!cpu_done_out) chk("cpu_done_timeout", 32'd0, 32'd1);
        rd = cpu_rdata_out;
        @(posedge clock);
        #1;
        cpu_req_in = 1'b0;
    endtask

    task automatic dbg_access(input bit we, input logic [31:0] a, input logic [31:0] wd,
                              input logic [1:0] sz, output int lat, output logic [31:0] rd);
        dbg_we_in = we; dbg_addr_in = a; dbg_wdata_in = wd; dbg_size_in = sz;
        dbg_req_in = 1'b1;
        lat = 0;
        @(negedge clock);
        while (!dbg_done_out && lat < 60) begin
            lat++;
            @(negedge clock);
        end
        if (!dbg_done_out) chk("dbg_done_timeout", 32'd0, 32'd1);
        rd = dbg_rdata_out;
        @(posedge clock);
        #1;
        dbg_req_in = 1'b0;
    endtask

    int          lat, lat_d;
    int          lat_c [4];
    logic [31:0] rd, rd_d;
    logic [31:0] rd_c [4];

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        #1 reset = 1'b0;
        #1;
        chk("rst_cpu_done", 32'(cpu_done_out), 32'd0);
        chk("rst_dbg_done", 32'(dbg_done_out), 32'd0);
        chk("rst_mem_re", 32'(mem_re_out), 32'd0);
        chk("rst_mem_we", 32'(mem_we_out), 32'd0);
        chk("rst_mem_size", 32'(mem_size_out), 32'h3);
        chk("rst_mem_addr", mem_addr_out, 32'd0);
        chk("rst_cpu_rdata", cpu_rdata_out, 32'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1;

        // cpu store alone, checking the issue cycle directly.
        fork
            cpu_access(1'b1, 32'h10, 32'hDEAD_BEEF, SzWord, lat, rd);
            begin
                @(negedge clock);
                @(negedge clock);
                chk("st_issue_we", 32'(mem_we_out), 32'd1);
                chk("st_issue_addr", mem_addr_out, 32'h10);
                chk("st_issue_wdata", mem_wdata_out, 32'hDEAD_BEEF);
                chk("st_issue_size", 32'(mem_size_out), 32'h3);
            end
        join
        chk("st_lat", 32'(lat), 32'd2);

        // cpu load alone: L+2 cycles, data held afterwards.
        @(posedge clock); #1;
        cpu_access(1'b0, 32'h20, 32'h0, SzWord, lat, rd);
        chk("ld_lat", 32'(lat), 32'd4);
        chk("ld_data", rd, 32'h1234_5678);
        repeat (3) @(negedge clock);
        chk("ld_data_held", cpu_rdata_out, 32'h1234_5678);
        @(posedge clock); #1;

        // dbg store then load; cpu reads dbg's write.
        dbg_access(1'b1, 32'h24, 32'hCAFE_F00D, SzHalf, lat, rd);
        chk("dbg_st_lat", 32'(lat), 32'd2);
        dbg_access(1'b0, 32'h10, 32'h0, SzWord, lat, rd);
        chk("dbg_ld_lat", 32'(lat), 32'd4);
        chk("dbg_ld_data", rd, 32'hDEAD_BEEF);
        cpu_access(1'b0, 32'h24, 32'h0, SzWord, lat, rd);
        chk("cpu_ld_dbgwr", rd, 32'hCAFE_F00D);
        chk("dbg_rdata_kept", dbg_rdata_out, 32'hDEAD_BEEF);

        // Simultaneous stores: cpu first, dbg granted in cpu's done cycle.
        @(posedge clock); #1;
        fork
            cpu_access(1'b1, 32'h30, 32'h1111_1111, SzByte, lat, rd);
            dbg_access(1'b1, 32'h34, 32'h2222_2222, SzHalf, lat_d, rd_d);
        join
        chk("both_cpu_lat", 32'(lat), 32'd2);
        chk("both_dbg_lat", 32'(lat_d), 32'd4);

        // Starvation: back-to-back cpu loads, dbg wins the 4th arbitration.
        @(posedge clock); #1;
        fork
            begin
                for (int j = 0; j < 4; j++) begin
                    cpu_access(1'b0, 32'h20, 32'h0, SzWord, lat_c[j], rd_c[j]);
                end
            end
            dbg_access(1'b0, 32'h30, 32'h0, SzWord, lat_d, rd_d);
        join
        chk("starve_cpu_lat0", 32'(lat_c[0]), 32'd4);
        chk("starve_cpu_lat2", 32'(lat_c[2]), 32'd4);
        chk("starve_cpu_lat3", 32'(lat_c[3]), 32'd9);
        chk("starve_dbg_lat", 32'(lat_d), 32'd19);
        chk("starve_dbg_data", rd_d, 32'h1111_1111);
        chk("starve_cpu_data", rd_c[3], 32'h1234_5678);

        // Fresh contention after the forced grant: cpu wins again.
        @(posedge clock); #1;
        fork
            cpu_access(1'b0, 32'h24, 32'h0, SzWord, lat, rd);
            dbg_access(1'b0, 32'h10, 32'h0, SzWord, lat_d, rd_d);
        join
        chk("post_cpu_lat", 32'(lat), 32'd4);
        chk("post_dbg_lat", 32'(lat_d), 32'd9);

        // Asynchronous reset in the middle of a cpu load.
        @(posedge clock); #1;
        cpu_we_in = 1'b0; cpu_addr_in = 32'h20; cpu_req_in = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #2;
        chk("mid_ld_re", 32'(mem_re_out), 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("abort_cpu_done", 32'(cpu_done_out), 32'd0);
        chk("abort_mem_re", 32'(mem_re_out), 32'd0);
        chk("abort_mem_we", 32'(mem_we_out), 32'd0);
        chk("abort_mem_size", 32'(mem_size_out), 32'h3);
        chk("abort_mem_addr", mem_addr_out, 32'd0);
        chk("abort_cpu_rdata", cpu_rdata_out, 32'd0);
        cpu_req_in = 1'b0;
        @(posedge clock);
        #3 reset = 1'b1;
        @(posedge clock); #1;
        cpu_access(1'b1, 32'h38, 32'h5555_AAAA, SzWord, lat, rd);
        chk("after_rst_lat", 32'(lat), 32'd2);

`ifdef DMEM_ARB_PERF_EN
        @(posedge clock); #1;
        perf_clr_in = 1'b1;
        @(posedge clock); #1;
        perf_clr_in = 1'b0;
        chk("perf_clr_stall", cpu_stall_cnt_out, 32'd0);
        chk("perf_clr_grant", 32'(dbg_grant_cnt_out), 32'd0);
        cpu_access(1'b0, 32'h20, 32'h0, SzWord, lat, rd);
        chk("perf_stall", cpu_stall_cnt_out, 32'd4);
        dbg_access(1'b1, 32'h3C, 32'h7777_7777, SzWord, lat, rd);
        chk("perf_grant", 32'(dbg_grant_cnt_out), 32'd1);
`endif

        repeat (3) @(posedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
